uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
- Byte-level command responder on the fabric side of the UART; consumes received bytes (rx_data/rx_ready) and produces reply bytes (tx_data/tx_start, throttled by tx_busy).
- Decodes a 2/3-byte read/write protocol into a single-cycle register-bank access port, e.g. for sensor counters and configuration.
- Sits between the UART wrapper and the sensor register bank; one reply byte per accepted command.

Parameters:
- ADDR_W, 8, register address width; the address byte is truncated to ADDR_W LSBs.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles (used only with UART_RESP_TIMEOUT_EN).
- ACK_BYTE, 8'h06, reply to a completed write.
- NAK_BYTE, 8'h15, reply to an unknown opcode.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- rx_data  in  8  received byte; valid when rx_ready=1
- rx_ready  in  1  single-cycle strobe, one per received byte
- tx_data  out  8  reply byte; held stable from tx_start until tx_busy deasserts
- tx_start  out  1  single-cycle transmit request
- tx_busy  in  1  transmitter busy
- reg_addr  out  ADDR_W  register address
- reg_rd_en  out  1  read strobe; reg_rd_data valid exactly 1 cycle later
- reg_rd_data  in  8  read data
- reg_wr_en  out  1  write strobe, 1 cycle
- reg_wr_data  out  8  write data
- overrun  out  1  sticky: byte arrived while a reply was pending; cleared only by reset
- timeout  out  1  1-cycle pulse on inter-byte timeout (0 when feature compiled out)

Behaviour:
- Interface decision: one clock (clk). reset_n is synchronous and active-low.
- Reset (reset_n=0 at posedge clk): state IDLE. Outputs tx_start, reg_rd_en, reg_wr_en, overrun and timeout are 0. tx_data, reg_addr and reg_wr_data are 0.
- Opcodes: 8'h52 'R' = read, followed by addr; 8'h57 'W' = write, followed by addr then data.
- State IDLE, on rx_ready:
  - 'R': go to GET_ADDR with op=read.
  - 'W': go to GET_ADDR with op=write.
  - Any other byte: load tx_data=NAK_BYTE, go to SEND.
- State GET_ADDR, on rx_ready: latch reg_addr.
  - op=read: go to READ.
  - op=write: go to GET_DATA.
- State GET_DATA, on rx_ready: latch reg_wr_data, pulse reg_wr_en for 1 cycle, load tx_data=ACK_BYTE, go to SEND.
- State READ: pulse reg_rd_en for 1 cycle, go to RCAP.
- State RCAP: tx_data<=reg_rd_data, go to SEND.
- State SEND: if tx_busy=0, pulse tx_start for 1 cycle and go to WAIT_TX. Otherwise stay in SEND.
- State WAIT_TX:
  - The first cycle after tx_start is a guard cycle; tx_busy is ignored.
  - After that, return to IDLE on the first cycle with tx_busy=0.
- Latency: tx_start asserts 3 cycles after the addr byte's rx_ready for a read, and 1 cycle after the data byte's rx_ready for a write or NAK, provided tx_busy=0.
- rx_ready in READ, RCAP, SEND or WAIT_TX: byte dropped, overrun<=1, state unaffected.
- rx_ready and a state transition in the same cycle: the byte is consumed by the current state only.
- reg_addr holds its last value between commands.
- Reset mid-command: partial command discarded, any pending reply abandoned, no strobes issued.

Optional Feature:
- Macro: UART_RESP_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in GET_ADDR and GET_DATA, reset on each rx_ready.
  - When it reaches TIMEOUT_CYCLES-1, return to IDLE, pulse timeout for 1 cycle, send no reply.
  - The counter width is $clog2(TIMEOUT_CYCLES).
- Without the macro: no counter logic; timeout is tied to 0; the block waits indefinitely for the next byte.

Decomposition:
- Shared package uart_resp_pkg holds:
  - State enum (IDLE, GET_ADDR, GET_DATA, READ, RCAP, SEND, WAIT_TX).
  - Opcode constants OP_READ=8'h52 and OP_WRITE=8'h57.
  - Default ACK/NAK constants.
- No sub-module is needed; the timeout counter stays inline under the macro.

Test Plan:
- Read: send 52,03 with reg[3]=A5 → one reg_rd_en with reg_addr=03, then tx_start with tx_data=A5, then return to IDLE after tx_busy cycles high→low.
- Write: send 57,10,3C → one reg_wr_en with reg_addr=10, reg_wr_data=3C, then tx_data=06; no reg_rd_en.
- Unknown opcode: send 41 → tx_data=15, no register strobes. Then send 52,00 → normal read reply.
- Back-pressure and overrun: hold tx_busy=1 for 500 cycles, then send 52,01 plus one extra byte → tx_start only after tx_busy falls, exactly once; overrun=1.
- Reset mid-command: send 57,10, pulse reset_n low for 1 cycle, then send 3C → no reg_wr_en, NAK reply (3C treated as an opcode).
- Timeout (macro on, TIMEOUT_CYCLES=100): send 52, then idle 100 cycles → timeout pulses once, no tx_start. Then send 52,02 → normal read reply.

Source files
------------

// File: rtl/uart_resp_pkg.sv
// Shared types and constants for the UART command responder.
package uart_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        READ,
        RCAP,
        SEND,
        WAIT_TX
    } state_t;

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] DEF_ACK  = 8'h06;
    localparam logic [7:0] DEF_NAK  = 8'h15;

endpackage

// File: rtl/uart_cmd_responder.sv
// Byte command responder: 'R' addr / 'W' addr data -> register access + one reply byte.
// Optional inter-byte timeout enabled by defining UART_RESP_TIMEOUT_EN.
module uart_cmd_responder
    import uart_resp_pkg::*;
#(
    parameter int          ADDR_W         = 8,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  ACK_BYTE       = DEF_ACK,
    parameter logic [7:0]  NAK_BYTE       = DEF_NAK
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_rd_en,
    input  logic [7:0]        reg_rd_data,
    output logic              reg_wr_en,
    output logic [7:0]        reg_wr_data,
    output logic              overrun,
    output logic              timeout
);

    state_t     state, state_d;
    logic       op_wr, op_wr_d;
    logic       guard, guard_d;
    logic       tx_ld, addr_ld, wdata_ld, wr_pulse, ovr_set;
    logic [7:0] tx_nxt;
    logic       to_hit, to_pulse;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            op_wr <= 1'b0;
            guard <= 1'b0;
        end else begin
            state <= state_d;
            op_wr <= op_wr_d;
            guard <= guard_d;
        end
    end

    always_comb begin
        state_d  = state;
        op_wr_d  = op_wr;
        guard_d  = guard;
        tx_ld    = 1'b0;
        tx_nxt   = NAK_BYTE;
        addr_ld  = 1'b0;
        wdata_ld = 1'b0;
        wr_pulse = 1'b0;
        ovr_set  = 1'b0;
        to_pulse = 1'b0;
        unique case (state)
            IDLE: if (rx_ready) begin
                if (rx_data == OP_READ) begin
                    state_d = GET_ADDR;
                    op_wr_d = 1'b0;
                end else if (rx_data == OP_WRITE) begin
                    state_d = GET_ADDR;
                    op_wr_d = 1'b1;
                end else begin
                    tx_ld   = 1'b1;
                    state_d = SEND;
                end
            end
            GET_ADDR: if (rx_ready) begin
                addr_ld = 1'b1;
                state_d = op_wr ? GET_DATA : READ;
            end else if (to_hit) begin
                to_pulse = 1'b1;
                state_d  = IDLE;
            end
            GET_DATA: if (rx_ready) begin
                wdata_ld = 1'b1;
                wr_pulse = 1'b1;
                tx_ld    = 1'b1;
                tx_nxt   = ACK_BYTE;
                state_d  = SEND;
            end else if (to_hit) begin
                to_pulse = 1'b1;
                state_d  = IDLE;
            end
            READ: state_d = RCAP;
            RCAP: begin
                tx_ld   = 1'b1;
                tx_nxt  = reg_rd_data;
                state_d = SEND;
            end
            SEND: if (!tx_busy) begin
                guard_d = 1'b1;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                // busy from the transmitter may lag tx_start by a cycle
                if (guard)         guard_d = 1'b0;
                else if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rx_ready && (state == READ || state == RCAP || state == SEND || state == WAIT_TX))
            ovr_set = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_data     <= '0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            reg_wr_en   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (tx_ld)    tx_data     <= tx_nxt;
            if (addr_ld)  reg_addr    <= rx_data[ADDR_W-1:0];
            if (wdata_ld) reg_wr_data <= rx_data;
            reg_wr_en <= wr_pulse;
            if (ovr_set)  overrun     <= 1'b1;
        end
    end

    assign tx_start  = (state == SEND) && !tx_busy;
    assign reg_rd_en = (state == READ);

`ifdef UART_RESP_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] to_cnt;
    logic             in_arg;

    assign in_arg = (state == GET_ADDR) || (state == GET_DATA);

    always_ff @(posedge clk) begin
        if (!reset_n || rx_ready || !in_arg) to_cnt <= '0;
        else                                 to_cnt <= to_cnt + 1'b1;
    end

    assign to_hit  = in_arg && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout = to_pulse;
`else
    logic unused_to_pulse;
    assign to_hit          = 1'b0;
    assign unused_to_pulse = to_pulse;
    assign timeout         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: vector table, corner sequences, random commands.
module tb_uart_cmd_responder;
    localparam int AW = 8;
`ifdef UART_RESP_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 1000000;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_ready = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic [AW-1:0] reg_addr;
    logic          reg_rd_en;
    logic [7:0]    reg_rd_data = '0;
    logic          reg_wr_en;
    logic [7:0]    reg_wr_data;
    logic          overrun;
    logic          timeout;

    uart_cmd_responder #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .reg_addr(reg_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
        .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
        .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // transmitter model: busy for tx_len cycles after each start, plus a forced hold
    int   tx_len = 2;
    int   busy_cnt = 0;
    logic force_busy = 1'b0;
    always @(posedge clk)
        if (tx_start) busy_cnt <= tx_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    assign tx_busy = force_busy | (busy_cnt != 0);

    // register bank: read data one cycle after the strobe
    logic [7:0] mem [256];
    logic       pre_we = 1'b0;
    logic [7:0] pre_addr = '0, pre_val = '0;
    always @(posedge clk) begin
        if (reg_rd_en) reg_rd_data <= mem[reg_addr];
        if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
        else if (pre_we) mem[pre_addr] <= pre_val;
    end

    // monitors
    logic [7:0]  tx_q[$];
    int          txc_q[$];
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    int          to_seen = 0, hold_err = 0;
    logic        hold_on = 1'b0;
    logic [7:0]  held = '0;
    always @(negedge clk) begin
        if (tx_start) begin
            tx_q.push_back(tx_data);
            txc_q.push_back(cyc);
            held    <= tx_data;
            hold_on <= 1'b1;
        end else if (hold_on) begin
            if (tx_data !== held) hold_err <= hold_err + 1;
            if (!tx_busy) hold_on <= 1'b0;
        end
        if (reg_wr_en) wr_q.push_back({reg_addr, reg_wr_data});
        if (reg_rd_en) rd_q.push_back(reg_addr);
        if (timeout)   to_seen <= to_seen + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int rx_cyc;
    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_ready = 1'b1; rx_cyc = cyc;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] v);
        pre_addr = a; pre_val = v; pre_we = 1'b1;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic wait_reply(input string nm, output logic [7:0] r, output int at);
        r = 'x; at = -1;
        for (int i = 0; i < 2000; i++) begin
            if (tx_q.size() != 0) begin
                r = tx_q.pop_front(); at = txc_q.pop_front();
                return;
            end
            @(posedge clk); #1;
        end
        chk({nm, "_reply_seen"}, 0, 1);
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         n;
        logic [7:0] reply;
        int         lat;
        bit         wr;
        logic [15:0] wexp;
        bit         rd;
        logic [7:0] ra;
    } vec_t;

    vec_t vt[11];
    logic [7:0] model_mem [16];

    initial begin
        logic [7:0] r;
        int at, t0, rel;

        vt[0]  = '{8'h52, 8'h03, 8'h00, 2, 8'hA5, 3, 0, 16'h0000, 1, 8'h03};
        vt[1]  = '{8'h57, 8'h10, 8'h3C, 3, 8'h06, 1, 1, 16'h103C, 0, 8'h00};
        vt[2]  = '{8'h41, 8'h00, 8'h00, 1, 8'h15, 1, 0, 16'h0000, 0, 8'h00};
        vt[3]  = '{8'h52, 8'h00, 8'h00, 2, 8'h5A, 3, 0, 16'h0000, 1, 8'h00};
        vt[4]  = '{8'h52, 8'h10, 8'h00, 2, 8'h3C, 3, 0, 16'h0000, 1, 8'h10};
        vt[5]  = '{8'h57, 8'hFF, 8'h00, 3, 8'h06, 1, 1, 16'hFF00, 0, 8'h00};
        vt[6]  = '{8'h52, 8'hFF, 8'h00, 2, 8'h00, 3, 0, 16'h0000, 1, 8'hFF};
        vt[7]  = '{8'h72, 8'h00, 8'h00, 1, 8'h15, 1, 0, 16'h0000, 0, 8'h00};
        vt[8]  = '{8'h00, 8'h00, 8'h00, 1, 8'h15, 1, 0, 16'h0000, 0, 8'h00};
        vt[9]  = '{8'h57, 8'hFF, 8'h81, 3, 8'h06, 1, 1, 16'hFF81, 0, 8'h00};
        vt[10] = '{8'h52, 8'hFF, 8'h00, 2, 8'h81, 3, 0, 16'h0000, 1, 8'hFF};

        // reset state
        idle(3);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_rd_en", reg_rd_en, 0);
        chk("rst_wr_en", reg_wr_en, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_wr_data", reg_wr_data, 0);
        reset_n = 1'b1;
        preload(8'h03, 8'hA5); preload(8'h00, 8'h5A); preload(8'h01, 8'hE1);
        preload(8'h02, 8'hC2); preload(8'hFF, 8'hC3);
        idle(2);

        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            wr_q.delete(); rd_q.delete();
            send_byte(vt[i].b0);
            if (vt[i].n > 1) send_byte(vt[i].b1);
            if (vt[i].n > 2) send_byte(vt[i].b2);
            t0 = rx_cyc;
            wait_reply(nm, r, at);
            idle(tx_len + 4);
            chk({nm, "_reply"}, r, vt[i].reply);
            chk({nm, "_latency"}, at - t0, vt[i].lat);
            chk({nm, "_wr_cnt"}, wr_q.size(), vt[i].wr);
            if (vt[i].wr && wr_q.size() != 0) chk({nm, "_wr"}, wr_q[0], vt[i].wexp);
            chk({nm, "_rd_cnt"}, rd_q.size(), vt[i].rd);
            if (vt[i].rd && rd_q.size() != 0) chk({nm, "_rd_addr"}, rd_q[0], vt[i].ra);
            if (i == 2) chk("addr_held_after_nak", reg_addr, 8'h10);
        end
        chk("no_overrun_yet", overrun, 0);

        // back-pressure with an extra byte while the read is in flight
        wr_q.delete(); rd_q.delete();
        force_busy = 1'b1;
        send_byte(8'h52); send_byte(8'h01); send_byte(8'h99);
        idle(500);
        chk("bp_no_start_while_busy", tx_q.size(), 0);
        rel = cyc;
        force_busy = 1'b0;
        wait_reply("bp", r, at);
        chk("bp_reply", r, 8'hE1);
        chk("bp_start_after_release", at >= rel, 1);
        idle(30);
        chk("bp_single_reply", tx_q.size(), 0);
        chk("bp_rd_cnt", rd_q.size(), 1);
        chk("bp_overrun", overrun, 1);

        // reset in the middle of a write
        wr_q.delete();
        send_byte(8'h57); send_byte(8'h10);
        reset_n = 1'b0; idle(1); reset_n = 1'b1;
        chk("midrst_overrun_clr", overrun, 0);
        chk("midrst_tx_data_clr", tx_data, 0);
        send_byte(8'h3C);
        t0 = rx_cyc;
        wait_reply("midrst", r, at);
        idle(tx_len + 4);
        chk("midrst_reply_nak", r, 8'h15);
        chk("midrst_latency", at - t0, 1);
        chk("midrst_no_wr", wr_q.size(), 0);

`ifdef UART_RESP_TIMEOUT_EN
        begin
            int to0;
            to0 = to_seen; rd_q.delete();
            send_byte(8'h52);
            idle(110);
            chk("to_pulse_once", to_seen - to0, 1);
            chk("to_no_reply", tx_q.size(), 0);
            chk("to_no_rd", rd_q.size(), 0);
            send_byte(8'h52); send_byte(8'h02);
            wait_reply("to_after", r, at);
            idle(tx_len + 4);
            chk("to_after_reply", r, 8'hC2);
        end
`endif

        // random commands against a command-level model
        for (int a = 0; a < 16; a++) begin
            model_mem[a] = 8'($urandom);
            preload(8'(a), model_mem[a]);
        end
        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [7:0] op, ad, dt, exp_r;
            int exp_wr, exp_rd;
            string nm;
            nm = $sformatf("rnd%0d", i);
            kind = $urandom_range(0, 9);
            ad = 8'($urandom_range(0, 15));
            dt = 8'($urandom);
            tx_len = $urandom_range(1, 8);
            wr_q.delete(); rd_q.delete();
            if (kind < 4) begin
                send_byte(8'h52); idle($urandom_range(0, 3)); send_byte(ad);
                exp_r = model_mem[ad[3:0]]; exp_wr = 0; exp_rd = 1;
            end else if (kind < 8) begin
                send_byte(8'h57); idle($urandom_range(0, 3)); send_byte(ad);
                idle($urandom_range(0, 3)); send_byte(dt);
                model_mem[ad[3:0]] = dt;
                exp_r = 8'h06; exp_wr = 1; exp_rd = 0;
            end else begin
                do op = 8'($urandom); while (op == 8'h52 || op == 8'h57);
                send_byte(op);
                exp_r = 8'h15; exp_wr = 0; exp_rd = 0;
            end
            wait_reply(nm, r, at);
            idle(tx_len + 4);
            chk({nm, "_reply"}, r, exp_r);
            chk({nm, "_wr_cnt"}, wr_q.size(), exp_wr);
            if (exp_wr == 1 && wr_q.size() != 0) chk({nm, "_wr"}, wr_q[0], {ad, dt});
            chk({nm, "_rd_cnt"}, rd_q.size(), exp_rd);
            if (exp_rd == 1 && rd_q.size() != 0) chk({nm, "_rd_addr"}, rd_q[0], ad);
        end

        chk("tx_data_stable_while_busy", hold_err, 0);
`ifndef UART_RESP_TIMEOUT_EN
        chk("timeout_never_fires", to_seen, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
